// File: rtl/cpa_serial_addsub.sv
// Multi-cycle carry-propagate adder/subtractor.
// A WIDTH-bit add or subtract is processed CHUNK bits per cycle, LSB chunk first,
// with the inter-chunk carry held in a register. The visible result registers
// (s/cout/ovf/zero) update together on the final chunk only, so a partially
// computed sum is never exposed.
module cpa_serial_addsub #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] s,
  output logic             cout,
  output logic             ovf,
  output logic             zero
);

  localparam int N  = WIDTH / CHUNK;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  // Reject parameter sets that do not tile the word into whole chunks.
  generate
    if (CHUNK < 1 || CHUNK > WIDTH || (WIDTH % CHUNK) != 0) begin : g_bad_params
      $error("cpa_serial_addsub: CHUNK must be in 1..WIDTH and divide WIDTH");
    end
  endgenerate

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_next;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;        // already inverted for subtract
  logic [WIDTH-1:0] r_acc;      // internal accumulator, never visible directly
  logic             r_carry;
  logic [WIDTH-1:0] r_s;
  logic             r_cout;
  logic             r_ovf;
  logic             r_zero;

  logic             w_accept;
  logic             w_last;
  int               w_base;
  logic [CHUNK-1:0] w_a_chunk;
  logic [CHUNK-1:0] w_b_chunk;
  logic [CHUNK:0]   w_sum;
  logic             w_msb_cin;
  logic [WIDTH-1:0] w_acc_next;

  // A new operation is only taken while not computing.
  assign w_accept = start && (r_state == S_IDLE || r_state == S_DONE);
  assign w_last   = (r_cnt == CW'(N - 1));

  // Chunk adder: slice the current chunk, add with held carry, merge into accumulator.
  always_comb begin
    w_base     = int'(r_cnt) * CHUNK;
    w_a_chunk  = r_a[w_base +: CHUNK];
    w_b_chunk  = r_b[w_base +: CHUNK];
    w_sum      = {1'b0, w_a_chunk} + {1'b0, w_b_chunk} + {{CHUNK{1'b0}}, r_carry};
    // On the top chunk, bit CHUNK-1 is the word MSB; its carry-in falls out of a^b^sum.
    w_msb_cin  = w_a_chunk[CHUNK-1] ^ w_b_chunk[CHUNK-1] ^ w_sum[CHUNK-1];
    w_acc_next = r_acc;
    w_acc_next[w_base +: CHUNK] = w_sum[CHUNK-1:0];
  end

  // Next-state logic for IDLE -> RUN -> DONE, with DONE able to re-accept directly.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (start) w_state_next = S_RUN;
      S_RUN:   if (w_last) w_state_next = S_DONE;
      S_DONE:  w_state_next = start ? S_RUN : S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Operand capture on accept, then one chunk per RUN cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt   <= '0;
      r_a     <= '0;
      r_b     <= '0;
      r_acc   <= '0;
      r_carry <= 1'b0;
    end else if (w_accept) begin
      r_cnt   <= '0;
      r_a     <= a;
      r_b     <= sub ? ~b : b;
      r_carry <= cin ^ sub;    // subtract is a + ~b + !borrow_in
    end else if (r_state == S_RUN) begin
      r_cnt   <= r_cnt + CW'(1);
      r_acc   <= w_acc_next;
      r_carry <= w_sum[CHUNK];
    end
  end

  // Visible result registers, updated together on the last chunk only.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_s    <= '0;
      r_cout <= 1'b0;
      r_ovf  <= 1'b0;
      r_zero <= 1'b0;
    end else if (r_state == S_RUN && w_last) begin
      r_s    <= w_acc_next;
      r_cout <= w_sum[CHUNK];
      r_ovf  <= w_msb_cin ^ w_sum[CHUNK];
      r_zero <= (w_acc_next == '0);
    end
  end

  assign busy = (r_state == S_RUN);
  assign done = (r_state == S_DONE);
  assign s    = r_s;
  assign cout = r_cout;
  assign ovf  = r_ovf;
  assign zero = r_zero;

endmodule
